// File: rtl/ser_pkg.sv
// Shared definitions for the PISO serializer: FSM state encodings and a
// constant-evaluable ceiling-log2 used to size the bit counter.
package ser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-position counter for one serial frame: cleared on accept, advances
// while enabled and saturates at WIDTH-1, flagging the final data bit.
module ser_bit_counter
   import ser_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CW    = clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          last
);

   assign last = (count == CW'(WIDTH - 1));

   // Position of the bit currently on sout; held at WIDTH-1 once reached.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !last) begin
         count <= count + CW'(1);
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with valid/ready input and back-to-back framing.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after every word.
module piso_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter bit LSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy,
   output logic             frame_done
);

   localparam int CW = clog2(WIDTH);
`ifdef SERIALIZER_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   state_t           state_r;
   logic [WIDTH-1:0] shift_r;
   logic             parity_r;
   logic             sout_r;
   logic             sout_valid_r;
   logic             busy_r;
   logic             frame_done_r;
   logic [CW-1:0]    count_s;
   logic             last_s;
   logic             last_cycle_s;
   logic             accept_s;
   logic             cnt_en_s;

   // The final bit of a frame is the parity bit when enabled, else data bit WIDTH-1.
   assign last_cycle_s = PAR_EN ? (state_r == ST_PARITY)
                                : ((state_r == ST_SHIFT) && last_s);
   assign in_ready     = !reset && ((state_r == ST_IDLE) || last_cycle_s);
   assign accept_s     = in_valid && in_ready;
   assign cnt_en_s     = (state_r == ST_SHIFT) && !last_s;

   assign sout       = sout_r;
   assign sout_valid = sout_valid_r;
   assign busy       = busy_r;
   assign frame_done = frame_done_r;

   ser_bit_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (accept_s),
      .en    (cnt_en_s),
      .count (count_s),
      .last  (last_s)
   );

   // Frame FSM; shift_r keeps only the bits not yet driven onto sout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         shift_r      <= '0;
         parity_r     <= 1'b0;
         sout_r       <= IDLE_LEVEL;
         sout_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
      end else if (accept_s) begin
         state_r      <= ST_SHIFT;
         sout_r       <= LSB_FIRST ? in_data[0] : in_data[WIDTH-1];
         shift_r      <= LSB_FIRST ? {1'b0, in_data[WIDTH-1:1]} : {in_data[WIDTH-2:0], 1'b0};
         parity_r     <= ^in_data;
         sout_valid_r <= 1'b1;
         busy_r       <= 1'b1;
         frame_done_r <= 1'b0;
      end else begin
         case (state_r)
            ST_SHIFT: begin
               if (!last_s) begin
                  state_r      <= ST_SHIFT;
                  sout_r       <= LSB_FIRST ? shift_r[0] : shift_r[WIDTH-1];
                  shift_r      <= LSB_FIRST ? {1'b0, shift_r[WIDTH-1:1]} : {shift_r[WIDTH-2:0], 1'b0};
                  sout_valid_r <= 1'b1;
                  busy_r       <= 1'b1;
                  // Pulse lines up with the bit that will be on sout next cycle.
                  frame_done_r <= !PAR_EN && (count_s == CW'(WIDTH - 2));
               end else if (PAR_EN) begin
                  state_r      <= ST_PARITY;
                  sout_r       <= parity_r;
                  sout_valid_r <= 1'b1;
                  busy_r       <= 1'b1;
                  frame_done_r <= 1'b1;
               end else begin
                  state_r      <= ST_IDLE;
                  sout_r       <= IDLE_LEVEL;
                  sout_valid_r <= 1'b0;
                  busy_r       <= 1'b0;
                  frame_done_r <= 1'b0;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               sout_r       <= IDLE_LEVEL;
               sout_valid_r <= 1'b0;
               busy_r       <= 1'b0;
               frame_done_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
